pmp_fault_ctrl: RTL and testbench
=================================

PMP_FAULT_CTRL -- requirements
Module: pmp_fault_ctrl

Interface
REQ-001 Parameter REQ_CHANNEL_NUM, default 3, SHALL be the number of checked request channels, index-matched to the PMP checker's v_pass bits.
REQ-002 Parameter ADDR_WIDTH, default 32, SHALL be the width of request addresses and of excp_tval.
REQ-003 Parameter ID_WIDTH, default 4, SHALL be the width of the request tag carried to the trap unit.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the reset: asynchronous assert, active-low.
REQ-006 v_req_vld  input  REQ_CHANNEL_NUM  SHALL mark each channel's request as valid this cycle.
REQ-007 v_req_addr  input  ADDR_WIDTH per channel  SHALL carry the checked address per channel.
REQ-008 v_req_mode  input  2 per channel  SHALL carry the access type: 01 load, 10 store, 11 fetch, 00 none.
REQ-009 v_req_id  input  ID_WIDTH per channel  SHALL carry the request tag per channel.
REQ-010 v_pass  input  REQ_CHANNEL_NUM  SHALL carry the PMP check result per channel, same cycle as the request.
REQ-011 v_blk  output  REQ_CHANNEL_NUM  SHALL, combinationally, tell each channel to suppress its memory access.
REQ-012 excp_vld  output  1  SHALL flag a held access-fault exception.
REQ-013 excp_cause  output  5  SHALL carry the mcause code of the held fault.
REQ-014 excp_tval  output  ADDR_WIDTH  SHALL carry the faulting address of the held fault.
REQ-015 excp_id  output  ID_WIDTH  SHALL carry the tag of the held fault.
REQ-016 excp_ack  input  1  SHALL be the trap unit's acceptance of the held exception.
REQ-017 flush  input  1  SHALL be the pipeline flush that discards any held exception.
REQ-018 fault_ovf  output  1  SHALL be a sticky flag marking faults dropped while HOLD.
REQ-019 fault_cnt  output  16  SHALL count accepted faults, saturating.

Function
REQ-020 A channel SHALL fault when v_req_vld=1, v_req_mode!=00 and v_pass=0; a channel with mode 00 SHALL never fault.
REQ-021 v_blk[i] SHALL be 1 when channel i faults, or when the FSM is in HOLD and v_req_vld[i]=1.
REQ-022 The FSM SHALL have two states: IDLE and HOLD.
REQ-023 In IDLE with one or more faults and flush=0, the FSM SHALL capture the lowest-index faulting channel and enter HOLD on the next edge.
REQ-024 Capture latency SHALL be one cycle: a fault in cycle N gives excp_vld=1 in cycle N+1.
REQ-025 Cause encoding SHALL be: fetch 1, load 5, store 7.
REQ-026 excp_cause, excp_tval and excp_id SHALL hold stable for the whole of HOLD.
REQ-027 In HOLD, excp_ack=1 or flush=1 SHALL return the FSM to IDLE on the next edge, with excp_vld=0 from that edge.
REQ-028 In HOLD, a new fault SHALL NOT replace the held one; it SHALL set fault_ovf, unless excp_ack or flush is high in the same cycle.
REQ-029 When ack and a new fault occur in the same HOLD cycle, the FSM SHALL stay in HOLD and capture the new fault; this counts as a back-to-back capture.
REQ-030 flush SHALL take priority over every capture: in a flush cycle no fault is captured, the FSM goes to IDLE, and fault_ovf clears.
REQ-031 fault_cnt SHALL increment by 1 on every capture and SHALL saturate at 16'hFFFF.
REQ-032 Outputs excp_cause, excp_tval and excp_id SHALL read 0 whenever excp_vld=0.
REQ-033 excp_ack while in IDLE SHALL be ignored.

Reset
REQ-034 While rst_n=0, the FSM SHALL be IDLE, and excp_vld, excp_cause, excp_tval, excp_id, fault_ovf and fault_cnt SHALL all be 0.
REQ-035 Reset mid-HOLD SHALL drop the held exception immediately and asynchronously, without waiting for a clock edge.
REQ-036 v_blk SHALL stay purely combinational and SHALL follow REQ-020/021 with the FSM in IDLE during reset.

Verification
REQ-037 Ch1 load to addr 0x8000_0010, id 3, pass=0 in cycle N -> v_blk=010 in N; from N+1: excp_vld=1, cause=5, tval=0x8000_0010, id=3; fault_cnt=1.
REQ-038 Ch0 fetch fault and ch2 store fault in the same cycle -> ch0 captured with cause=1; v_blk=101.
REQ-039 In HOLD, ch2 store fault with no ack -> held data unchanged, fault_ovf=1, v_blk[2]=1; then ack -> IDLE next cycle.
REQ-040 In HOLD, ack in the same cycle as a ch1 load fault -> stays HOLD with the new cause=5 and tval; fault_cnt=2.
REQ-041 In HOLD, flush together with a ch0 fault -> IDLE, excp_vld=0, fault_ovf=0, no capture.
REQ-042 fault_cnt preloaded to 0xFFFF via repeated faults, one more fault -> fault_cnt stays 0xFFFF; rst_n pulse mid-HOLD -> all outputs 0 with no clock edge.

Source files
------------

// File: rtl/pmp_fault_ctrl.sv
// PMP access-fault controller: blocks faulting requests and holds one
// access-fault exception for the trap unit.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   v_req_vld     per-channel request valid            [CH-1:0]
//   v_req_addr    per-channel address, channel i at    [i*ADDR_WIDTH +: ADDR_WIDTH]
//   v_req_mode    per-channel access type (01 ld, 10 st, 11 fetch) [i*2 +: 2]
//   v_req_id      per-channel request tag              [i*ID_WIDTH +: ID_WIDTH]
//   v_pass        per-channel PMP check result         [CH-1:0]
//   v_blk         per-channel access suppress (combinational)
//   excp_vld      held exception present
//   excp_cause    mcause of held fault (fetch 1, load 5, store 7)
//   excp_tval     faulting address of held fault
//   excp_id       tag of held fault
//   excp_ack      trap unit accepts the held exception
//   flush         pipeline flush, discards held exception
//   fault_ovf     sticky: a fault was dropped while holding
//   fault_cnt     saturating count of captured faults
module pmp_fault_ctrl #(
   parameter int REQ_CHANNEL_NUM = 3,
   parameter int ADDR_WIDTH      = 32,
   parameter int ID_WIDTH        = 4
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic [REQ_CHANNEL_NUM-1:0]            v_req_vld,
   input  logic [REQ_CHANNEL_NUM*ADDR_WIDTH-1:0] v_req_addr,
   input  logic [REQ_CHANNEL_NUM*2-1:0]          v_req_mode,
   input  logic [REQ_CHANNEL_NUM*ID_WIDTH-1:0]   v_req_id,
   input  logic [REQ_CHANNEL_NUM-1:0]            v_pass,
   output logic [REQ_CHANNEL_NUM-1:0]            v_blk,
   output logic                                  excp_vld,
   output logic [4:0]                            excp_cause,
   output logic [ADDR_WIDTH-1:0]                 excp_tval,
   output logic [ID_WIDTH-1:0]                   excp_id,
   input  logic                                  excp_ack,
   input  logic                                  flush,
   output logic                                  fault_ovf,
   output logic [15:0]                           fault_cnt
);

   typedef enum logic {
      IDLE,
      HOLD
   } state_t;

   state_t state;

   logic [REQ_CHANNEL_NUM-1:0] fault;
   logic                       any_fault;
   logic [ADDR_WIDTH-1:0]      sel_addr;
   logic [1:0]                 sel_mode;
   logic [ID_WIDTH-1:0]        sel_id;
   logic [4:0]                 sel_cause;
   logic                       capture;
   logic                       release_hold;
   logic                       ovf_set;

   // Mode 00 carries no access and so can never fault.
   always_comb begin
      fault = '0;
      for (int i = 0; i < REQ_CHANNEL_NUM; i++) begin
         fault[i] = v_req_vld[i]
                  & (v_req_mode[i*2 +: 2] != 2'b00)
                  & ~v_pass[i];
      end
   end

   assign any_fault = |fault;

   // While holding, every valid request is blocked so nothing slips past
   // the pending trap.
   always_comb begin
      v_blk = fault;
      if (state == HOLD) begin
         v_blk = fault | v_req_vld;
      end
   end

   // Scan from the top down so the lowest faulting index wins.
   always_comb begin
      sel_addr = '0;
      sel_mode = '0;
      sel_id   = '0;
      for (int i = REQ_CHANNEL_NUM - 1; i >= 0; i--) begin
         if (fault[i]) begin
            sel_addr = v_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_mode = v_req_mode[i*2 +: 2];
            sel_id   = v_req_id[i*ID_WIDTH +: ID_WIDTH];
         end
      end
   end

   always_comb begin
      sel_cause = 5'd0;
      unique case (sel_mode)
         2'b01:   sel_cause = 5'd5;
         2'b10:   sel_cause = 5'd7;
         2'b11:   sel_cause = 5'd1;
         default: sel_cause = 5'd0;
      endcase
   end

   // An ack in HOLD frees the slot in the same cycle, so a coincident
   // fault is taken back-to-back. Flush overrides any capture.
   assign capture = ~flush & any_fault
                  & ((state == IDLE) | excp_ack);

   assign release_hold = (state == HOLD)
                       & (flush | excp_ack)
                       & ~capture;

   assign ovf_set = (state == HOLD) & any_fault
                  & ~excp_ack & ~flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         excp_vld   <= 1'b0;
         excp_cause <= '0;
         excp_tval  <= '0;
         excp_id    <= '0;
         fault_ovf  <= 1'b0;
         fault_cnt  <= '0;
      end else begin
         if (flush) begin
            fault_ovf <= 1'b0;
         end else if (ovf_set) begin
            fault_ovf <= 1'b1;
         end

         if (capture) begin
            state      <= HOLD;
            excp_vld   <= 1'b1;
            excp_cause <= sel_cause;
            excp_tval  <= sel_addr;
            excp_id    <= sel_id;
            if (fault_cnt != 16'hFFFF) begin
               fault_cnt <= fault_cnt + 16'd1;
            end
         end else if (release_hold) begin
            state      <= IDLE;
            excp_vld   <= 1'b0;
            excp_cause <= '0;
            excp_tval  <= '0;
            excp_id    <= '0;
         end
      end
   end

endmodule

// File: tb/tb_pmp_fault_ctrl.sv
// Scoreboard bench for pmp_fault_ctrl: directed faults push expected
// exceptions, a negedge monitor pops and compares each presentation.
module tb_pmp_fault_ctrl;

   localparam int N  = 3;
   localparam int AW = 32;
   localparam int IW = 4;

   typedef struct packed {
      logic [4:0]    cause;
      logic [AW-1:0] tval;
      logic [IW-1:0] id;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    v_req_vld;
   logic [N*AW-1:0] v_req_addr;
   logic [N*2-1:0]  v_req_mode;
   logic [N*IW-1:0] v_req_id;
   logic [N-1:0]    v_pass;
   logic [N-1:0]    v_blk;
   logic            excp_vld;
   logic [4:0]      excp_cause;
   logic [AW-1:0]   excp_tval;
   logic [IW-1:0]   excp_id;
   logic            excp_ack;
   logic            flush;
   logic            fault_ovf;
   logic [15:0]     fault_cnt;

   int   n_chk  = 0;
   int   n_pass = 0;
   bit   sb_off = 1'b1;
   bit   fresh  = 1'b1;
   exp_t cur    = '0;
   exp_t sbq[$];

   always #5 clk = ~clk;

   pmp_fault_ctrl #(
      .REQ_CHANNEL_NUM(N),
      .ADDR_WIDTH(AW),
      .ID_WIDTH(IW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .v_req_vld(v_req_vld),
      .v_req_addr(v_req_addr),
      .v_req_mode(v_req_mode),
      .v_req_id(v_req_id),
      .v_pass(v_pass),
      .v_blk(v_blk),
      .excp_vld(excp_vld),
      .excp_cause(excp_cause),
      .excp_tval(excp_tval),
      .excp_id(excp_id),
      .excp_ack(excp_ack),
      .flush(flush),
      .fault_ovf(fault_ovf),
      .fault_cnt(fault_cnt)
   );

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", nm, act, exp);
   endtask

   task automatic clr();
      v_req_vld  = '0;
      v_req_addr = '0;
      v_req_mode = '0;
      v_req_id   = '0;
      v_pass     = '1;
   endtask

   task automatic set_ch(int ch, logic [1:0] mode, logic [AW-1:0] addr,
                         logic [IW-1:0] id, logic pass);
      v_req_vld[ch]            = 1'b1;
      v_req_mode[ch*2 +: 2]    = mode;
      v_req_addr[ch*AW +: AW]  = addr;
      v_req_id[ch*IW +: IW]    = id;
      v_pass[ch]               = pass;
   endtask

   task automatic push(logic [4:0] c, logic [AW-1:0] t, logic [IW-1:0] i);
      exp_t e;
      e.cause = c;
      e.tval  = t;
      e.id    = i;
      sbq.push_back(e);
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   // Monitor: a new presentation starts after excp_vld low or an ack/flush.
   always @(negedge clk) begin
      if (!sb_off) begin
         if (excp_vld) begin
            if (fresh) begin
               if (sbq.size() == 0) chk("sb_unexpected", 1, 0);
               else cur = sbq.pop_front();
            end
            chk("sb_cause", excp_cause, cur.cause);
            chk("sb_tval", excp_tval, cur.tval);
            chk("sb_id", excp_id, cur.id);
         end else begin
            chk("idle_zero", {excp_cause, excp_tval, excp_id}, 0);
         end
      end
      fresh = !excp_vld || excp_ack || flush;
   end

   initial begin
      rst_n    = 1'b1;
      excp_ack = 1'b0;
      flush    = 1'b0;
      clr();
      #1 rst_n = 1'b0;

      // Reset state; v_blk still combinational during reset
      set_ch(1, 2'b01, 32'h8000_0010, 4'd3, 1'b0);
      @(negedge clk);
      chk("rst_vld", excp_vld, 0);
      chk("rst_fields", {excp_cause, excp_tval, excp_id}, 0);
      chk("rst_ovf", fault_ovf, 0);
      chk("rst_cnt", fault_cnt, 0);
      chk("rst_blk", v_blk, 3'b010);
      nxt();
      chk("rst_nocap", excp_vld, 0);
      clr();
      rst_n  = 1'b1;
      sb_off = 1'b0;

      // Single load fault on ch1
      set_ch(1, 2'b01, 32'h8000_0010, 4'd3, 1'b0);
      push(5'd5, 32'h8000_0010, 4'd3);
      @(negedge clk);
      chk("ld_blk", v_blk, 3'b010);
      nxt();
      clr();
      @(negedge clk);
      chk("ld_vld", excp_vld, 1);
      chk("ld_cnt", fault_cnt, 1);
      excp_ack = 1'b1;
      nxt();
      excp_ack = 1'b0;
      @(negedge clk);
      chk("ack_idle", excp_vld, 0);

      // Two faults: lowest index (ch0 fetch) wins
      set_ch(0, 2'b11, 32'h0000_1000, 4'd1, 1'b0);
      set_ch(2, 2'b10, 32'h0000_2000, 4'd2, 1'b0);
      push(5'd1, 32'h0000_1000, 4'd1);
      @(negedge clk);
      chk("pri_blk", v_blk, 3'b101);
      nxt();
      clr();
      @(negedge clk);
      chk("pri_cnt", fault_cnt, 2);

      // Fault while holding: dropped, sticky overflow, hold blocks valid
      set_ch(2, 2'b10, 32'h0000_2004, 4'd6, 1'b0);
      set_ch(0, 2'b01, 32'h0000_5000, 4'd7, 1'b1);
      @(negedge clk);
      chk("hold_blk", v_blk, 3'b101);
      nxt();
      clr();
      @(negedge clk);
      chk("ovf_set", fault_ovf, 1);
      chk("ovf_vld", excp_vld, 1);
      chk("ovf_cnt", fault_cnt, 2);
      excp_ack = 1'b1;
      nxt();
      excp_ack = 1'b0;
      @(negedge clk);
      chk("ovf_ack_idle", excp_vld, 0);
      chk("ovf_sticky", fault_ovf, 1);

      // Ack with coincident fault: back-to-back capture
      set_ch(0, 2'b01, 32'h0000_3000, 4'd4, 1'b0);
      push(5'd5, 32'h0000_3000, 4'd4);
      nxt();
      clr();
      @(negedge clk);
      chk("b2b_cnt1", fault_cnt, 3);
      excp_ack = 1'b1;
      set_ch(1, 2'b01, 32'h0000_4000, 4'd5, 1'b0);
      push(5'd5, 32'h0000_4000, 4'd5);
      nxt();
      excp_ack = 1'b0;
      clr();
      @(negedge clk);
      chk("b2b_vld", excp_vld, 1);
      chk("b2b_cnt2", fault_cnt, 4);

      // Flush in HOLD with a fault: no capture, overflow cleared
      flush = 1'b1;
      set_ch(0, 2'b11, 32'h0000_6000, 4'd8, 1'b0);
      @(negedge clk);
      chk("fl_blk", v_blk, 3'b001);
      nxt();
      flush = 1'b0;
      clr();
      @(negedge clk);
      chk("fl_vld", excp_vld, 0);
      chk("fl_ovf", fault_ovf, 0);
      chk("fl_cnt", fault_cnt, 4);

      // Flush in IDLE with a fault: no capture
      flush = 1'b1;
      set_ch(2, 2'b10, 32'h0000_7000, 4'd9, 1'b0);
      nxt();
      flush = 1'b0;
      clr();
      @(negedge clk);
      chk("fli_vld", excp_vld, 0);
      chk("fli_cnt", fault_cnt, 4);

      // Mode 00 never faults
      set_ch(1, 2'b00, 32'h0000_7777, 4'd1, 1'b0);
      @(negedge clk);
      chk("m00_blk", v_blk, 3'b000);
      nxt();
      clr();
      @(negedge clk);
      chk("m00_vld", excp_vld, 0);

      // Ack in IDLE ignored
      excp_ack = 1'b1;
      nxt();
      excp_ack = 1'b0;
      @(negedge clk);
      chk("ackidle_vld", excp_vld, 0);
      chk("ackidle_cnt", fault_cnt, 4);

      // ch1 fetch beats ch2 load
      set_ch(1, 2'b11, 32'h0000_A000, 4'd2, 1'b0);
      set_ch(2, 2'b01, 32'h0000_B000, 4'd3, 1'b0);
      push(5'd1, 32'h0000_A000, 4'd2);
      nxt();
      clr();
      @(negedge clk);
      chk("pri2_cnt", fault_cnt, 5);
      excp_ack = 1'b1;
      nxt();
      excp_ack = 1'b0;
      @(negedge clk);
      chk("pri2_idle", excp_vld, 0);

      // Saturation: one capture per cycle up to 0xFFFF, then one more
      sb_off   = 1'b1;
      excp_ack = 1'b1;
      set_ch(0, 2'b10, 32'h0000_C000, 4'd1, 1'b0);
      repeat (65530) nxt();
      @(negedge clk);
      chk("sat_reach", fault_cnt, 16'hFFFF);
      nxt();
      @(negedge clk);
      chk("sat_hold", fault_cnt, 16'hFFFF);
      excp_ack = 1'b0;
      set_ch(0, 2'b10, 32'h0000_D000, 4'd2, 1'b0);
      nxt();
      clr();
      @(negedge clk);
      chk("sat_vld", excp_vld, 1);
      chk("sat_tval", excp_tval, 32'h0000_C000);
      chk("sat_cause", excp_cause, 5'd7);
      chk("sat_ovf", fault_ovf, 1);

      // Asynchronous reset mid-HOLD
      nxt();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_vld", excp_vld, 0);
      chk("arst_fields", {excp_cause, excp_tval, excp_id}, 0);
      chk("arst_ovf", fault_ovf, 0);
      chk("arst_cnt", fault_cnt, 0);
      nxt();
      rst_n = 1'b1;
      nxt();

      chk("sb_drain", sbq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end

endmodule
